// File: rtl/lcd12864_bus_arbiter.sv
// Two-requester arbiter for an LCD12864 8-bit parallel write bus: runs the
// power-on init sequence, then serves writes round-robin with EN timing.
module lcd12864_bus_arbiter #(
  parameter int PWR_CYC   = 2000000,
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 4,
  parameter int EXEC_CYC  = 4000,
  parameter int CLR_CYC   = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_dat,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_dat,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);
  localparam int M0   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int M1   = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
  localparam int M2   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int M3   = (M0 > M1) ? M0 : M1;
  localparam int MAXC = (M3 > M2) ? M3 : M2;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {S_PWR, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    dat_q, dat_d;
  logic          rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic          rr_q, rr_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          en_q, busy_q;
  logic          dispatch, load, load_rs;
  logic [7:0]    load_dat;
  logic          is_clr;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign is_clr = !rs_q && (dat_q == 8'h01 || dat_q == 8'h02);

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    rs_d     = rs_q;
    dat_d    = dat_q;
    rdy0_d   = 1'b0;
    rdy1_d   = 1'b0;
    rr_d     = rr_q;
    idx_d    = idx_q;
    done_d   = done_q;
    dispatch = 1'b0;
    load     = 1'b0;
    load_rs  = 1'b0;
    load_dat = 8'h00;
    case (state_q)
      S_PWR: if (cnt_q == '0) begin
        load     = 1'b1;
        load_dat = init_byte(idx_q);
      end
      S_IDLE: dispatch = 1'b1;
      S_SETUP: if (cnt_q == '0) begin
        state_d = S_PULSE;
        cnt_d   = CW'(EN_CYC - 1);
      end
      S_PULSE: if (cnt_q == '0) begin
        state_d = S_HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
      end
      S_HOLD: if (cnt_q == '0) begin
        state_d = S_EXEC;
        cnt_d   = is_clr ? CW'(CLR_CYC - 1) : CW'(EXEC_CYC - 1);
      end
      // The end of the execute wait arbitrates directly, so back-to-back
      // writes occupy the bus with no idle gap between them.
      S_EXEC: if (cnt_q == '0) begin
        if (!done_q) begin
          if (idx_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d    = idx_q + 2'd1;
            load     = 1'b1;
            load_dat = init_byte(idx_q + 2'd1);
          end
        end else begin
          dispatch = 1'b1;
        end
      end
      default: state_d = S_PWR;
    endcase

    if (dispatch) begin
      if (!done_q) begin
        load     = 1'b1;
        load_dat = init_byte(idx_q);
      end else if (req0_valid && (!req1_valid || rr_q)) begin
        load     = 1'b1;
        load_rs  = req0_rs;
        load_dat = req0_dat;
        rdy0_d   = 1'b1;
        rr_d     = 1'b0;
      end else if (req1_valid) begin
        load     = 1'b1;
        load_rs  = req1_rs;
        load_dat = req1_dat;
        rdy1_d   = 1'b1;
        rr_d     = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (load) begin
      state_d = S_SETUP;
      cnt_d   = CW'(SETUP_CYC - 1);
      rs_d    = load_rs;
      dat_d   = load_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWR;
      cnt_q   <= CW'(PWR_CYC - 1);
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      rr_q    <= 1'b1;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      en_q    <= (state_d == S_PULSE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign req0_ready = rdy0_q;
  assign req1_ready = rdy1_q;
  assign init_done  = done_q;
  assign busy       = busy_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_dat    = dat_q;
endmodule

// File: tb/tb_lcd12864_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected LCD writes, a negedge monitor
// pops them on every EN rise and records EN/grant/init_done timing.
module tb_lcd12864_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_rs, req1_valid, req1_rs;
  logic [7:0] req0_dat, req1_dat;
  logic       req0_ready, req1_ready, init_done, busy;
  logic       lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_dat;

  lcd12864_bus_arbiter #(
    .PWR_CYC(10), .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2), .EXEC_CYC(5), .CLR_CYC(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_dat(req0_dat), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_dat(req1_dat), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int rise_cyc[$];
  int rise_at = 0;
  int done_rise = -1;
  logic en_prev = 1'b0, done_prev = 1'b0, rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: checks every bus write against the scoreboard queue.
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      rise_cyc.push_back(cyc);
      rise_at = cyc;
      if (exp_q.size() == 0) chk("unexpected_write", {23'd0, lcd_rs, lcd_dat}, 32'h1FF);
      else chk("write_rs_dat", {23'd0, lcd_rs, lcd_dat}, {23'd0, exp_q.pop_front()});
      chk("rw_low", lcd_rw, 0);
    end
    if (!lcd_en && en_prev && rst_n) chk("en_width", cyc - rise_at, 3);
    if (init_done && !done_prev) done_rise = cyc;
    if (req0_ready || req1_ready) begin
      chk("ready_after_init", init_done, 1);
      chk("ready_single_cycle", rdy_prev, 0);
      chk("ready_onehot", req0_ready & req1_ready, 0);
    end
    en_prev   = lcd_en;
    done_prev = init_done;
    rdy_prev  = req0_ready | req1_ready;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output int side);
    side = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req0_ready || req1_ready) begin
        side = req1_ready ? 1 : 0;
        break;
      end
    end
    if (side < 0) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("idle_reached", busy, 0);
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  initial begin
    int rel, side, t0, t1, n;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_dat = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_dat = 8'h00;
    repeat (3) tick();
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_dat", lcd_dat, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);

    // Power-on init with no requests
    push_init();
    rst_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < 200 && !init_done; i++) tick();
    chk("init_done_set", init_done, 1);
    chk("init_en_count", rise_cyc.size(), 4);
    if (rise_cyc.size() == 4)
      for (int i = 0; i < 4; i++) chk("init_en_rise_time", rise_cyc[i] - rel, 12 * (i + 1));
    chk("init_done_time", done_rise - rel, 73);
    tick();
    chk("idle_after_init", busy, 0);

    // Both requesters continuously valid: strict alternation from r0
    req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_dat = 8'h31;
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? 9'h130 : 9'h131);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(side);
      chk("rr_side", side, k % 2);
      if (k > 0) chk("rr_grant_gap", cyc - t0, 12);
      t0 = cyc;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Requester 0 alone, data write
    req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h41;
    exp_q.push_back(9'h141);
    wait_ready(side);
    req0_valid = 1'b0;
    chk("r0_side", side, 0);
    chk("r0_bus", {lcd_rs, lcd_dat}, 9'h141);
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      n++;
      tick();
    end
    chk("r0_busy_cycles", n, 12);

    // Requester 1 clear command: long execute wait before next grant
    req1_valid = 1'b1; req1_rs = 1'b0; req1_dat = 8'h01;
    exp_q.push_back(9'h001);
    wait_ready(side);
    t0 = cyc;
    chk("clr_side", side, 1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h42;
    exp_q.push_back(9'h142);
    wait_ready(side);
    t1 = cyc;
    req0_valid = 1'b0;
    chk("after_clr_side", side, 0);
    chk("clr_grant_gap", t1 - t0, 27);

    // Reset during PULSE, request pending while init reruns
    for (int i = 0; i < 50 && !lcd_en; i++) tick();
    chk("pulse_reached", lcd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_en_low", lcd_en, 0);
    chk("abort_init_done", init_done, 0);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_dat = 8'h55;
    rise_cyc.delete();
    push_init();
    exp_q.push_back(9'h155);
    repeat (3) tick();
    rst_n = 1'b1;
    rel = cyc;
    wait_ready(side);
    req0_valid = 1'b0;
    chk("early_req_side", side, 0);
    chk("early_req_grant_time", cyc - rel, 74);
    chk("reinit_done_time", done_rise - rel, 73);
    chk("reinit_en_count", rise_cyc.size(), 4);
    if (rise_cyc.size() > 0) chk("reinit_first_rise", rise_cyc[0] - rel, 12);
    wait_idle();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
